// File: rtl/tetris_key_scheduler_pkg.sv
// tetris_key_scheduler_pkg: shared action/state types and scan-code constants for the key scheduler
package tetris_key_scheduler_pkg;
  typedef enum logic [2:0] {
    A_NONE,
    A_LEFT,
    A_RIGHT,
    A_SOFT,
    A_ROT,
    A_DROP,
    A_HOLD
  } action_t;
  typedef enum logic [1:0] {
    H_IDLE,
    H_DAS,
    H_ARR
  } hfsm_t;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ROT   = 8'h75;
  localparam logic [7:0] SC_DROP  = 8'h29;
  localparam logic [7:0] SC_HOLD  = 8'h12;
  // one-hot key map in keys_held order {hold,drop,rot,down,right,left}
  function automatic logic [5:0] key_onehot(input logic [7:0] sc);
    return {sc == SC_HOLD, sc == SC_DROP, sc == SC_ROT, sc == SC_DOWN, sc == SC_RIGHT, sc == SC_LEFT};
  endfunction
endpackage

// File: rtl/tetris_key_scheduler_repeat_timer.sv
// tetris_key_scheduler_repeat_timer: counter that pulses expire once per period while enabled
module tetris_key_scheduler_repeat_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         restart,
  input  logic [W-1:0] period,
  output logic         expire
);
  localparam logic [W-1:0] ONE = 1;
  logic [W-1:0] cnt;
  assign expire = en && (cnt == period - ONE);
  // count while enabled; restart or expiry returns to zero, the top value holds instead of wrapping
  always_ff @(posedge clk)
    if (rst || restart || expire) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + ONE;
endmodule

// File: rtl/tetris_key_scheduler.sv
// tetris_key_scheduler: turns keyboard make/break events into queued one-shot game actions
module tetris_key_scheduler
  import tetris_key_scheduler_pkg::*;
#(
  parameter int DAS_CYCLES  = 17_000_000,
  parameter int ARR_CYCLES  = 5_000_000,
  parameter int SOFT_CYCLES = 3_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       make_break,
  input  logic       key_event_valid,
  input  logic       action_ready,
  output logic       action_valid,
  output logic [2:0] action_code,
  output logic [5:0] keys_held
);
  localparam int MAXP = DAS_CYCLES > ARR_CYCLES ? (DAS_CYCLES > SOFT_CYCLES ? DAS_CYCLES : SOFT_CYCLES)
                                                : (ARR_CYCLES > SOFT_CYCLES ? ARR_CYCLES : SOFT_CYCLES);
  localparam int W = $clog2(MAXP) + 1;
  localparam logic [W-1:0] DAS_P  = W'(DAS_CYCLES);
  localparam logic [W-1:0] ARR_P  = W'(ARR_CYCLES);
  localparam logic [W-1:0] SOFT_P = W'(SOFT_CYCLES);
  logic kv_q, ev_q, mb_q, dir, dir_n, h_rst, h_exp, s_exp;
  logic [7:0] sc_q;
  logic [5:0] key, fresh, brk, held, pend, set, clr;
  logic [1:0] hheld, hbrk;
  hfsm_t h_st, h_nx;
  action_t code;
  // register the strobe so only its rising edge yields a single event
  always_ff @(posedge clk)
    if (rst) begin
      kv_q <= 1'b0;
      ev_q <= 1'b0;
      sc_q <= '0;
      mb_q <= 1'b0;
    end else begin
      kv_q <= key_event_valid;
      ev_q <= key_event_valid & ~kv_q;
      sc_q <= scan_code;
      mb_q <= make_break;
    end
  assign key   = ev_q ? key_onehot(sc_q) : '0;
  assign fresh = mb_q ? key & ~held : '0;
  assign brk   = mb_q ? '0 : key & held;
  assign hheld = held[1:0];
  assign hbrk  = brk[1:0];
  // horizontal FSM: key events override the DAS->ARR step taken on timer expiry
  always_comb begin
    h_nx  = h_st;
    dir_n = dir;
    h_rst = 1'b0;
    if (h_exp && h_st == H_DAS) h_nx = H_ARR;
    if (fresh[0] || fresh[1]) begin
      h_nx  = H_DAS;
      dir_n = fresh[1];
      h_rst = 1'b1;
    end else if (h_st != H_IDLE && hbrk[dir]) begin
      h_nx  = hheld[~dir] ? H_DAS : H_IDLE;
      dir_n = ~dir;
      h_rst = 1'b1;
    end
  end
  // horizontal state and active direction
  always_ff @(posedge clk)
    if (rst) begin
      h_st <= H_IDLE;
      dir  <= 1'b0;
    end else begin
      h_st <= h_nx;
      dir  <= dir_n;
    end
  tetris_key_scheduler_repeat_timer #(.W(W)) u_htimer (
    .clk(clk),
    .rst(rst),
    .en(h_st != H_IDLE),
    .restart(h_rst),
    .period(h_st == H_ARR ? ARR_P : DAS_P),
    .expire(h_exp)
  );
  tetris_key_scheduler_repeat_timer #(.W(W)) u_stimer (
    .clk(clk),
    .rst(rst),
    .en(held[2]),
    .restart(fresh[2] | brk[2]),
    .period(SOFT_P),
    .expire(s_exp)
  );
  assign set = fresh | {3'b000, s_exp, dir & h_exp, ~dir & h_exp};
  // priority encode pending actions and pick the one bit an acceptance clears
  always_comb begin
    code = pend[4] ? A_DROP : pend[5] ? A_HOLD : pend[3] ? A_ROT :
           pend[0] ? A_LEFT : pend[1] ? A_RIGHT : pend[2] ? A_SOFT : A_NONE;
    clr  = !action_ready ? 6'b000000 : pend[4] ? 6'b010000 : pend[5] ? 6'b100000 :
           pend[3] ? 6'b001000 : pend[0] ? 6'b000001 : pend[1] ? 6'b000010 : {3'b000, pend[2], 2'b00};
  end
  // held-key map and pending bits; a new request in the accept cycle keeps its bit set
  always_ff @(posedge clk)
    if (rst) begin
      held <= '0;
      pend <= '0;
    end else begin
      held <= mb_q ? held | key : held & ~key;
      pend <= (pend & ~clr) | set;
    end
  assign action_valid = |pend;
  assign action_code  = code;
  assign keys_held    = held;
endmodule
